// File: rtl/alu_share_arb_pkg.sv
// ============================================================================
// Module   : alu_share_arb_pkg
// Purpose  : ALU control codes, port count and request record for alu_share_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLL  = 3'b111
    } alu_ctrl_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_ctrl_e       ctrl;
        logic            f7b5;
    } alu_req_t;

endpackage

`default_nettype wire

// File: rtl/alu_share_arb_alu.sv
// ============================================================================
// Module   : alu_share_arb_alu
// Purpose  : Single-cycle integer ALU with result and branch/zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arb_alu
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_ctrl_e        i_ctrl,
    input  logic [2:0]       i_funct3,
    input  logic             i_f7b5,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_result;

    assign w_shamt = i_b[4:0];

    always_comb begin
        w_result = '0;
        case (i_ctrl)
            ALU_ADD:  w_result = i_a + i_b;
            ALU_SUB:  w_result = i_a - i_b;
            ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_OR:   w_result = i_a | i_b;
            ALU_XOR:  w_result = i_a ^ i_b;
            ALU_SR:   w_result = i_f7b5 ? WIDTH'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_SLL:  w_result = i_a << w_shamt;
            default:  w_result = '0;
        endcase
    end

    // funct3 = 001 (BNE) inverts the flag; every other code reports result == 0.
    always_comb begin
        o_zero = ~|w_result;
        if (i_funct3 == 3'b001) begin
            o_zero = |w_result;
        end
    end

    assign o_result = w_result;

endmodule

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin sharing of one ALU between two valid/ready requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req0_f7b5,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic             req1_f7b5,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero
);

    logic [NUM_PORTS-1:0] w_req_valid;
    logic [NUM_PORTS-1:0] w_resp_ready;
    logic [NUM_PORTS-1:0] w_slot_free;
    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_grant;
    alu_req_t             w_req [NUM_PORTS];
    alu_req_t             w_sel;
    logic [WIDTH-1:0]     w_alu_result;
    logic                 w_alu_zero;

    logic                 r_rr_ptr;
    logic [NUM_PORTS-1:0] r_resp_valid;
    logic [NUM_PORTS-1:0] r_resp_zero;
    logic [WIDTH-1:0]     r_resp_result [NUM_PORTS];

    assign w_req_valid  = {req1_valid, req0_valid};
    assign w_resp_ready = {resp1_ready, resp0_ready};

    // Request record operand fields are XLEN wide; WIDTH is expected to match.
    assign w_req[0] = '{a: XLEN'(req0_a), b: XLEN'(req0_b),
                        ctrl: alu_ctrl_e'(req0_ctrl), f7b5: req0_f7b5};
    assign w_req[1] = '{a: XLEN'(req1_a), b: XLEN'(req1_b),
                        ctrl: alu_ctrl_e'(req1_ctrl), f7b5: req1_f7b5};

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            // A slot draining this cycle can be refilled in the same cycle.
            assign w_slot_free[gi] = !r_resp_valid[gi] || w_resp_ready[gi];
            assign w_elig[gi]      = w_req_valid[gi] && w_slot_free[gi];
        end
    endgenerate

    always_comb begin
        w_grant = '0;
        if (!reset) begin
            case (w_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant[r_rr_ptr] = 1'b1;
                default: w_grant = '0;
            endcase
        end
    end

    assign w_sel = w_grant[1] ? w_req[1] : w_req[0];

    alu_share_arb_alu #(
        .WIDTH   (WIDTH)
    ) u_alu (
        .i_a      (WIDTH'(w_sel.a)),
        .i_b      (WIDTH'(w_sel.b)),
        .i_ctrl   (w_sel.ctrl),
        .i_funct3 (3'b000),
        .i_f7b5   (w_sel.f7b5),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (|w_grant) begin
            // Hand priority to the port that was not just served.
            r_rr_ptr <= w_grant[0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset) begin
                r_resp_valid[i]  <= 1'b0;
                r_resp_zero[i]   <= 1'b0;
                r_resp_result[i] <= '0;
            end else if (w_grant[i]) begin
                r_resp_valid[i]  <= 1'b1;
                r_resp_zero[i]   <= w_alu_zero;
                r_resp_result[i] <= w_alu_result;
            end else if (w_resp_ready[i]) begin
                r_resp_valid[i]  <= 1'b0;
            end
        end
    end

    assign req0_ready   = w_grant[0];
    assign req1_ready   = w_grant[1];
    assign resp0_valid  = r_resp_valid[0];
    assign resp1_valid  = r_resp_valid[1];
    assign resp0_zero   = r_resp_zero[0];
    assign resp1_zero   = r_resp_zero[1];
    assign resp0_result = r_resp_result[0];
    assign resp1_result = r_resp_result[1];

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Self-checking scoreboard bench for alu_share_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_f7b5;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_ctrl;
    logic        resp0_valid, resp0_ready, resp0_zero;
    logic [31:0] resp0_result;
    logic        req1_valid, req1_ready, req1_f7b5;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_ctrl;
    logic        resp1_valid, resp1_ready, resp1_zero;
    logic [31:0] resp1_result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ctrl    (req0_ctrl),
        .req0_f7b5    (req0_f7b5),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp0_result (resp0_result),
        .resp0_zero   (resp0_zero),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ctrl    (req1_ctrl),
        .req1_f7b5    (req1_f7b5),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp1_result (resp1_result),
        .resp1_zero   (resp1_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU: returns {zero, result}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c, input logic f);
        logic [31:0]        r;
        logic signed [31:0] sa;
        sa = a;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = f ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = (a < b) ? 32'd1 : 32'd0;
            default: r = a << b[4:0];
        endcase
        return {(r == 32'd0), r};
    endfunction

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (resp0_valid && resp0_ready) begin
                if (q0.size() == 0) begin
                    chk("p0_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    chk("p0_result", 64'(resp0_result), 64'(e[31:0]));
                    chk("p0_zero", 64'(resp0_zero), 64'(e[32]));
                end
            end
            if (resp1_valid && resp1_ready) begin
                if (q1.size() == 0) begin
                    chk("p1_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    chk("p1_result", 64'(resp1_result), 64'(e[31:0]));
                    chk("p1_zero", 64'(resp1_zero), 64'(e[32]));
                end
            end
            if (req0_valid && req0_ready) q0.push_back(model(req0_a, req0_b, req0_ctrl, req0_f7b5));
            if (req1_valid && req1_ready) q1.push_back(model(req1_a, req1_b, req1_ctrl, req1_f7b5));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic f);
        req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; req0_f7b5 = f;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic f);
        req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; req1_f7b5 = f;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic g;
        reset = 1'b1;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd2, 3'd0, 1'b0);
        set1(1'b1, 32'd3, 32'd4, 3'd0, 1'b0);

        repeat (2) begin
            @(negedge clk);
            chk("rst_ready0", 64'(req0_ready), 64'd0);
            chk("rst_ready1", 64'(req1_ready), 64'd0);
            chk("rst_valid0", 64'(resp0_valid), 64'd0);
            chk("rst_valid1", 64'(resp1_valid), 64'd0);
            chk("rst_result0", 64'(resp0_result), 64'd0);
            chk("rst_result1", 64'(resp1_result), 64'd0);
        end

        // Single-port add
        step();
        reset = 1'b0;
        set0(1'b1, 32'd5, 32'd7, 3'b000, 1'b0);
        set1(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
        @(negedge clk);
        chk("add_ready", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", 64'(resp0_valid), 64'd1);
        chk("add_result", 64'(resp0_result), 64'd12);
        chk("add_zero", 64'(resp0_zero), 64'd0);

        // Contention: port 0 served last, so port 1 wins first
        step();
        set0(1'b1, 32'd9, 32'd9, 3'b001, 1'b0);
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0);
        g = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("cont_ready0", 64'(req0_ready), 64'(g == 1'b0));
            chk("cont_ready1", 64'(req1_ready), 64'(g == 1'b1));
            g = ~g;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("cont_result0", 64'(resp0_result), 64'd0);
        chk("cont_zero0", 64'(resp0_zero), 64'd1);
        chk("cont_result1", 64'(resp1_result), 64'd1);

        // Backpressure on port 0 must not stall port 1
        step();
        set0(1'b1, 32'd1, 32'd4, 3'b111, 1'b0);
        @(negedge clk);
        chk("bp_first_ready0", 64'(req0_ready), 64'd1);
        step();
        resp0_ready = 1'b0;
        set1(1'b1, 32'h8000_0000, 32'd4, 3'b101, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready0", 64'(req0_ready), 64'd0);
            chk("bp_ready1", 64'(req1_ready), 64'd1);
            chk("bp_valid0", 64'(resp0_valid), 64'd1);
            chk("bp_hold0", 64'(resp0_result), 64'h10);
            if (i > 0) chk("bp_sra1", 64'(resp1_result), 64'hF800_0000);
            step();
        end
        resp0_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Drain and refill port 1 in the same cycle
        step();
        set1(1'b1, 32'd5, 32'd3, 3'b110, 1'b0);
        resp1_ready = 1'b0;
        @(negedge clk);
        chk("dr_first_ready1", 64'(req1_ready), 64'd1);
        step();
        set1(1'b1, 32'd1, 32'd2, 3'b110, 1'b0);
        @(negedge clk);
        chk("dr_blocked_ready1", 64'(req1_ready), 64'd0);
        step();
        resp1_ready = 1'b1;
        @(negedge clk);
        chk("dr_refill_ready1", 64'(req1_ready), 64'd1);
        chk("dr_old_result1", 64'(resp1_result), 64'd0);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("dr_new_valid1", 64'(resp1_valid), 64'd1);
        chk("dr_new_result1", 64'(resp1_result), 64'd1);
        chk("dr_new_zero1", 64'(resp1_zero), 64'd0);

        // Reset while port 0 is stalled; port 0 served last before reset
        step();
        set0(1'b1, 32'd3, 32'd4, 3'b000, 1'b0);
        resp0_ready = 1'b0;
        @(negedge clk);
        chk("ms_ready0", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("ms_stall_valid0", 64'(resp0_valid), 64'd1);
        step();
        reset = 1'b1;
        set0(1'b1, 32'd1, 32'd1, 3'b000, 1'b0);
        set1(1'b1, 32'd2, 32'd2, 3'b000, 1'b0);
        @(negedge clk);
        chk("ms_rst_ready0", 64'(req0_ready), 64'd0);
        chk("ms_rst_ready1", 64'(req1_ready), 64'd0);
        step();
        reset = 1'b0;
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("ms_cleared_valid0", 64'(resp0_valid), 64'd0);
        chk("ms_cleared_result0", 64'(resp0_result), 64'd0);
        chk("ms_first_ready0", 64'(req0_ready), 64'd1);
        chk("ms_first_ready1", 64'(req1_ready), 64'd0);
        step();
        @(negedge clk);
        chk("ms_second_ready1", 64'(req1_ready), 64'd1);
        chk("ms_second_ready0", 64'(req0_ready), 64'd0);
        step();

        // Mixed random traffic checked by the scoreboard
        repeat (400) begin
            set0($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            set1($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) req0_b = req0_a;
            if ($urandom_range(0, 4) == 0) req1_b = req1_a;
            resp0_ready = $urandom_range(0, 2) != 0;
            resp1_ready = $urandom_range(0, 2) != 0;
            step();
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            step();
        end
        @(negedge clk);
        chk("drain_q0_empty", 64'(q0.size()), 64'd0);
        chk("drain_q1_empty", 64'(q1.size()), 64'd0);
        chk("drain_valid0", 64'(resp0_valid), 64'd0);
        chk("drain_valid1", 64'(resp1_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one ALU datapath between two requesters, port 0 (main datapath issue) and port 1 (auxiliary unit, e.g. address/compare helper).
- Each port uses a valid/ready request handshake and a valid/ready response handshake.
- Arbitration is round-robin. One operation is accepted per cycle.
- The result and zero flag are registered into a per-port response slot, one cycle after acceptance.

Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  WIDTH  port 0 operand a.
- req0_b  in  WIDTH  port 0 operand b.
- req0_ctrl  in  3  port 0 ALU control code.
- req0_f7b5  in  1  port 0 funct7[5]; selects SRA over SRL.
- resp0_valid  out  1  port 0 result slot full.
- resp0_ready  in  1  port 0 consumer takes result this cycle.
- resp0_result  out  WIDTH  port 0 registered ALU result.
- resp0_zero  out  1  port 0 registered zero flag.
- req1_* / resp1_*  same directions, widths and meanings as port 0, for port 1.

Behaviour:
- Reset (synchronous, active-high):
  - resp0_valid = resp1_valid = 0.
  - resp*_result = 0, resp*_zero = 0.
  - rr_ptr = 0, so port 0 has priority first.
- Slot free condition:
  - slot_free_i = !resp_i_valid || resp_i_ready.
  - A full slot draining in the same cycle counts as free, so throughput is 1 op/cycle per port.
- Eligibility: elig_i = req_i_valid && slot_free_i.
- Grant (combinational):
  - Exactly one of elig0/elig1 set: grant that port.
  - Both set: grant port rr_ptr.
  - Neither set: no grant.
- req_i_ready = grant_i.
  - req_i_ready may depend on the other port's valid.
  - Requesters must not make valid depend on ready.
- Datapath: the granted port's a, b, ctrl and f7b5 are muxed into the single ALU. The ALU's funct3 input is tied to 0.
- On the rising edge with grant_i:
  - resp_i_result <= ALU result; resp_i_zero <= ALU zero flag; resp_i_valid <= 1.
  - Latency is exactly 1 cycle: accepted at cycle N, response visible at cycle N+1.
- Response slot with no grant:
  - resp_i_ready && resp_i_valid: resp_i_valid <= 0; data holds its last value.
  - resp_i_valid && !resp_i_ready: slot holds result and zero stable. req_i_ready = 0 until the slot drains.
- rr_ptr update:
  - After any grant to port i, rr_ptr <= the other port (1-i), giving strict alternation under contention.
  - No change when there is no grant.
- The two ports are independent. A stalled port 0 response never blocks port 1 grants, and vice versa.
- Operand/width rules (inherited from the ALU):
  - Shift amount uses b[4:0].
  - SLT is signed, SLTU is unsigned.
  - Undefined ctrl codes produce result 0 and zero = 1.
- Reset asserted mid-operation: pending response data is discarded, all valids drop next edge, and no request is accepted in a reset cycle (req*_ready = 0 while reset = 1).
- No combinational path from resp*_ready to resp*_valid or resp*_result.

Decomposition:
- Shared package holds:
  - ALU control codes: ALU_ADD=000, ALU_SUB=001, ALU_SLT=010, ALU_OR=011, ALU_XOR=100, ALU_SR=101, ALU_SLTU=110, ALU_SLL=111.
  - NUM_PORTS=2.
  - A request struct typedef {a, b, ctrl, f7b5}.
- One sub-module, the existing alu, instantiated once. The round-robin grant logic stays inline.

Test Plan:
- Reset then idle: hold reset 2 cycles -> resp0/1_valid=0, results 0, req*_ready=0 during reset.
- Single port add:
  - Stimulus: port 0 valid, a=5, b=7, ctrl=000, resp0_ready=1.
  - Expect: req0_ready=1; next cycle resp0_valid=1, result=12, zero=0.
- Contention alternation:
  - Stimulus: both valid continuously, resp ready=1; port 0 SUB 9-9, port 1 SLT a=0xFFFFFFFF b=1.
  - Expect: grants 0,1,0,1... Port 0 result 0 with zero=1; port 1 result 1.
- Backpressure isolation:
  - Stimulus: port 0 resp0_ready=0 after first result 0x10 (SLL 1<<4); port 1 issues SRA a=0x80000000 b=4, f7b5=1.
  - Expect: port 0 slot holds 0x10 and req0_ready=0. Port 1 is granted every cycle with result 0xF8000000.
- Drain-and-refill same cycle:
  - Stimulus: port 1 slot full, resp1_ready=1, req1 valid SLTU 1<2.
  - Expect: req1_ready=1 that cycle; next cycle resp1_valid=1, result=1 with no bubble.
- Reset mid-stall: resp0_valid=1, resp0_ready=0, assert reset 1 cycle -> resp0_valid=0 and rr_ptr=0; the next simultaneous request grants port 0 first.
